// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_e;

    // Counter width able to represent 0..width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: async-reset flop with
// clock enable and a hold/left/right/load next-state mux.
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  usr_mode_e mode,
    input  logic      from_left,
    input  logic      from_right,
    input  logic      d,
    output logic      q
);

    logic q_next;

    always_comb begin
        q_next = q;
        case (mode)
            USR_HOLD: q_next = q;
            USR_SHR:  q_next = from_left;
            USR_SHL:  q_next = from_right;
            USR_LOAD: q_next = d;
            default:  q_next = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_BIT;
        else if (en)
            q <= q_next;
    end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with shift counter and frame-done pulse.
// Optional rotate feature (ROT port) enabled by defining USR_ROTATE_EN.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EN,
    input  logic [1:0]                    MODE,
    input  logic [WIDTH-1:0]              D,
    input  logic                          SIN_L,
    input  logic                          SIN_R,
`ifdef USR_ROTATE_EN
    input  logic                          ROT,
`endif
    output logic [WIDTH-1:0]              Q,
    output logic [WIDTH-1:0]              nQ,
    output logic                          SOUT_L,
    output logic                          SOUT_R,
    output logic [cnt_w(WIDTH)-1:0]       SHIFT_CNT,
    output logic                          FRAME_DONE
);

    localparam int unsigned     CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    usr_mode_e        mode;
    logic             shr_in;
    logic             shl_in;
    logic [WIDTH-1:0] left_src;
    logic [WIDTH-1:0] right_src;
    logic             shifting;
    logic             wrap;

    assign mode = usr_mode_e'(MODE);

`ifdef USR_ROTATE_EN
    assign shr_in = ROT ? Q[0]       : SIN_L;
    assign shl_in = ROT ? Q[WIDTH-1] : SIN_R;
`else
    assign shr_in = SIN_L;
    assign shl_in = SIN_R;
`endif

    // Neighbour vectors: bit i sees its higher (left) and lower (right) neighbour.
    assign left_src  = {shr_in, Q[WIDTH-1:1]};
    assign right_src = {Q[WIDTH-2:0], shl_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_bit_cell #(
            .RST_BIT(RESET_VAL[i])
        ) u_cell (
            .clk       (CLK),
            .rst       (RST),
            .en        (EN),
            .mode      (mode),
            .from_left (left_src[i]),
            .from_right(right_src[i]),
            .d         (D[i]),
            .q         (Q[i])
        );
    end

    assign nQ     = ~Q;
    assign SOUT_L = Q[WIDTH-1];
    assign SOUT_R = Q[0];

    always_comb begin
        shifting = EN && ((mode == USR_SHR) || (mode == USR_SHL));
        wrap     = shifting && (SHIFT_CNT == CNT_LAST);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SHIFT_CNT  <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= wrap;
            if (EN) begin
                if (mode == USR_LOAD)
                    SHIFT_CNT <= '0;
                else if (shifting)
                    SHIFT_CNT <= wrap ? '0 : SHIFT_CNT + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8, RESET_VAL=0);
// define USR_ROTATE_EN to also exercise rotation.
module tb_universal_shift_reg;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [1:0] MODE;
    logic [7:0] D;
    logic       SIN_L;
    logic       SIN_R;
    logic       rot;
    logic [7:0] Q;
    logic [7:0] nQ;
    logic       SOUT_L;
    logic       SOUT_R;
    logic [3:0] SHIFT_CNT;
    logic       FRAME_DONE;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mq;
    logic [3:0] mcnt;
    logic       mfd;

    universal_shift_reg #(
        .WIDTH    (8),
        .RESET_VAL(8'h00)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .MODE      (MODE),
        .D         (D),
        .SIN_L     (SIN_L),
        .SIN_R     (SIN_R),
`ifdef USR_ROTATE_EN
        .ROT       (rot),
`endif
        .Q         (Q),
        .nQ        (nQ),
        .SOUT_L    (SOUT_L),
        .SOUT_R    (SOUT_R),
        .SHIFT_CNT (SHIFT_CNT),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        logic [7:0] nexp;
        nexp = ~e.q;
        check({tag, ".q"},      Q,          e.q);
        check({tag, ".nq"},     nQ,         nexp);
        check({tag, ".sout_l"}, SOUT_L,     e.q[7]);
        check({tag, ".sout_r"}, SOUT_R,     e.q[0]);
        check({tag, ".cnt"},    SHIFT_CNT,  e.cnt);
        check({tag, ".fd"},     FRAME_DONE, e.fd);
    endtask

    // Drive one cycle of stimulus, predict the result, compare after the edge.
    task automatic step(input string tag, input logic en, input logic [1:0] mode,
                        input logic [7:0] d, input logic sl, input logic sr, input logic r);
        logic shift;
        logic in_l;
        logic in_r;
        exp_t e;
        @(negedge CLK);
        EN = en; MODE = mode; D = d; SIN_L = sl; SIN_R = sr; rot = r;
        shift = en && (mode == 2'b01 || mode == 2'b10);
`ifdef USR_ROTATE_EN
        in_l = r ? mq[0] : sl;
        in_r = r ? mq[7] : sr;
`else
        in_l = sl;
        in_r = sr;
`endif
        mfd = shift && (mcnt == 4'd7);
        if (en) begin
            case (mode)
                2'b01:   mq = {in_l, mq[7:1]};
                2'b10:   mq = {mq[6:0], in_r};
                2'b11:   mq = d;
                default: mq = mq;
            endcase
            if (mode == 2'b11)
                mcnt = 4'd0;
            else if (shift)
                mcnt = (mcnt == 4'd7) ? 4'd0 : mcnt + 4'd1;
        end
        e.q = mq; e.cnt = mcnt; e.fd = mfd;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    logic [7:0] bits3;
    exp_t       e_rst;

    initial begin
        RST = 1'b1; EN = 1'b0; MODE = 2'b00; D = '0; SIN_L = 1'b0; SIN_R = 1'b0; rot = 1'b0;
        mq = 8'h00; mcnt = 4'd0; mfd = 1'b0;
        e_rst.q = 8'h00; e_rst.cnt = 4'd0; e_rst.fd = 1'b0;
        #3;
        check_outputs("por", e_rst);
        #4 RST = 1'b0;

        // 1: async reset mid-frame with Q=A5 (0x52 shifted left with SIN_R=1)
        step("t1_load", 1, 2'b11, 8'h52, 0, 0, 0);
        step("t1_shl",  1, 2'b10, 8'h00, 0, 1, 0);
        check("t1_pre_q", Q, 8'hA5);
        #1 RST = 1'b1;
        #1;
        check_outputs("t1_rst", e_rst);
        mq = 8'h00; mcnt = 4'd0; mfd = 1'b0;
        #1 RST = 1'b0;

        // 2: parallel load
        step("t2_load", 1, 2'b11, 8'h3C, 1, 1, 0);
        check("t2_nq", nQ, 8'hC3);

        // 3: eight shift-lefts from 00 assemble B2, then frame pulse clears
        step("t3_clr", 1, 2'b11, 8'h00, 0, 0, 0);
        bits3 = 8'b1011_0010;
        for (int i = 7; i >= 0; i--)
            step("t3_shl", 1, 2'b10, 8'h00, 0, bits3[i], 0);
        check("t3_q", Q, 8'hB2);
        check("t3_fd", FRAME_DONE, 1'b1);
        step("t3_hold", 1, 2'b00, 8'h00, 1, 1, 0);
        check("t3_fd_off", FRAME_DONE, 1'b0);

        // 4: shift right then EN=0 hold
        step("t4_load", 1, 2'b11, 8'h81, 0, 0, 0);
        step("t4_shr",  1, 2'b01, 8'h00, 1, 0, 0);
        check("t4_q", Q, 8'hC0);
        for (int i = 0; i < 3; i++)
            step("t4_dis", 0, 2'b01, 8'hFF, 0, 1, 0);
        check("t4_cnt", SHIFT_CNT, 4'd1);

        // 5: load mid-frame restarts the count
        for (int i = 0; i < 4; i++)
            step("t5_pre", 1, 2'b01, 8'h00, i[0], 0, 0);
        step("t5_load", 1, 2'b11, 8'hFF, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step("t5_shift", 1, (i < 4) ? 2'b10 : 2'b01, 8'h00, 0, 0, 0);
        check("t5_fd", FRAME_DONE, 1'b1);
        step("t5_after", 1, 2'b00, 8'h00, 0, 0, 0);

`ifdef USR_ROTATE_EN
        // 6: rotation
        step("t6_load", 1, 2'b11, 8'h81, 0, 0, 0);
        step("t6_rol",  1, 2'b10, 8'h00, 0, 0, 1);
        check("t6_rol_q", Q, 8'h03);
        step("t6_ror1", 1, 2'b01, 8'h00, 0, 0, 1);
        step("t6_ror2", 1, 2'b01, 8'h00, 0, 0, 1);
        check("t6_ror_q", Q, 8'hC0);
`endif

        // mixed random traffic
        for (int i = 0; i < 200; i++) begin
            logic r;
`ifdef USR_ROTATE_EN
            r = 1'($urandom_range(0, 1));
`else
            r = 1'b0;
`endif
            step("rand", 1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
